// File: rtl/mem_responder.sv
// mem_responder: wait-stated word RAM target returning a one-cycle ack with read data or error
module mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ack,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                  state;
  logic [3:0]              cnt;
  logic                    we_q;
  logic [31:0]             addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    legal;
  logic                    commit;
  assign idx    = addr_q[ADDR_WIDTH+1:2];
  assign legal  = (addr_q[1:0] == 2'b00) && (addr_q[31:ADDR_WIDTH+2] == '0);
  assign commit = (state == WAIT) && req && (cnt == 4'd0);
  assign busy   = state != IDLE;
  // RAM write port; contents survive reset, only a legal committed write touches them
  always_ff @(posedge clk)
    if (commit && legal && we_q) mem[idx] <= wdata_q;
  // control FSM: latch request, count wait states, commit, then one-cycle response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          we_q    <= we;
          addr_q  <= addr;
          wdata_q <= wdata;
          cnt     <= 4'(WAIT_CYCLES);
          state   <= WAIT;
        end
        WAIT: begin
          if (!req) state <= IDLE;
          else if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            ack   <= 1'b1;
            err   <= !legal;
            state <= RESP;
            if (!legal) rdata <= '0;
            else if (!we_q) rdata <= mem[idx];
          end
        end
        default: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and randomized checks of mem_responder against a behavioural RAM model
module tb_mem_responder;
  localparam int W = 2;
  logic clk = 0, rst_n = 0;
  logic req = 0, we = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic ack, err, busy;
  logic [31:0] rdata;
  logic req0 = 0, we0 = 0;
  logic [31:0] addr0 = 0, wdata0 = 0;
  logic ack0, err0, busy0;
  logic [31:0] rdata0;
  int n_chk = 0, n_fail = 0;
  logic [31:0] mem_m [1024];
  logic [31:0] exp_rd = 0;

  mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy));

  mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ack(ack0), .err(err0), .rdata(rdata0), .busy(busy0));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one full transaction on the W-wait-state instance, checked against the model
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input string tag);
    logic bad;
    logic got;
    int k;
    bad = (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
    @(negedge clk);
    we = w; addr = a; wdata = d; req = 1;
    @(posedge clk);
    @(negedge clk);
    we = ~w; addr = $urandom; wdata = $urandom;
    k = 0; got = 0;
    while (!got && k < 20) begin
      @(posedge clk); #1; k++;
      if (ack) got = 1;
      else chk({tag, " busy_wait"}, {31'd0, busy}, 32'd1);
    end
    chk({tag, " ack_seen"}, {31'd0, got}, 32'd1);
    chk({tag, " latency"}, k, W + 1);
    if (bad) exp_rd = 0;
    else if (w) mem_m[a[11:2]] = d;
    else exp_rd = mem_m[a[11:2]];
    chk({tag, " err"}, {31'd0, err}, {31'd0, bad});
    chk({tag, " rdata"}, rdata, exp_rd);
    @(negedge clk);
    req = 0;
    @(posedge clk); #1;
    chk({tag, " ack_clr"}, {31'd0, ack}, 32'd0);
    chk({tag, " err_clr"}, {31'd0, err}, 32'd0);
    chk({tag, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int sel;
    #12;
    chk("rst ack", {31'd0, ack}, 32'd0);
    chk("rst err", {31'd0, err}, 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 16; i++) txn(1'b1, i * 4, $urandom, "init");
    // 1: write then read back with 2 wait states
    txn(1'b1, 32'h10, 32'hDEADBEEF, "t1 wr");
    txn(1'b0, 32'h10, 32'h0, "t1 rd");
    chk("t1 value", rdata, 32'hDEADBEEF);
    // 2: zero wait states on the second instance
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req0 = 1; we0 = (i == 0); addr0 = 0; wdata0 = 32'hA5A5_0F0F;
      @(posedge clk); #1;
      chk("t2 busy1", {31'd0, busy0}, 32'd1);
      chk("t2 noack", {31'd0, ack0}, 32'd0);
      @(posedge clk); #1;
      chk("t2 ack", {31'd0, ack0}, 32'd1);
      chk("t2 busy2", {31'd0, busy0}, 32'd1);
      chk("t2 err", {31'd0, err0}, 32'd0);
      @(negedge clk); req0 = 0;
      @(posedge clk); #1;
      chk("t2 ackclr", {31'd0, ack0}, 32'd0);
      chk("t2 idle", {31'd0, busy0}, 32'd0);
    end
    chk("t2 rdata", rdata0, 32'hA5A5_0F0F);
    // 3: abort in WAIT leaves RAM untouched
    @(negedge clk); req = 1; we = 1; addr = 32'h20; wdata = 32'h1234;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); req = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t3 noack", {31'd0, ack}, 32'd0);
      chk("t3 idle", {31'd0, busy}, 32'd0);
    end
    txn(1'b0, 32'h20, 32'h0, "t3 rd");
    // 4: misaligned write rejected, word 0x20 unchanged
    txn(1'b1, 32'h22, 32'hFFFF_FFFF, "t4 wr");
    txn(1'b0, 32'h20, 32'h0, "t4 rd");
    // 5: out-of-range read
    txn(1'b0, 32'h1000, 32'h0, "t5 rd");
    // 6: async reset during WAIT of a write
    @(negedge clk); req = 1; we = 1; addr = 32'h30; wdata = ~mem_m[12];
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); rst_n = 0; #1;
    chk("t6 ack", {31'd0, ack}, 32'd0);
    chk("t6 busy", {31'd0, busy}, 32'd0);
    chk("t6 rdata", rdata, 32'd0);
    req = 0; exp_rd = 0;
    @(negedge clk); rst_n = 1;
    txn(1'b0, 32'h30, 32'h0, "t6 rd");
    // randomized mix of legal, misaligned and out-of-range accesses
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 4);
      a = $urandom_range(0, 15) * 4;
      if (sel == 0) a = a + $urandom_range(1, 3);
      else if (sel == 1) a = a | ($urandom_range(1, 1000) << 12);
      txn($urandom_range(0, 1) == 1, a, $urandom, "rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
